// File: rtl/execute_mul_pipe.sv
// rtl/execute_mul_pipe.sv - pipelined signed/unsigned integer multiply unit for the Y execute slot
module execute_mul_pipe #(
    parameter int         WIDTH   = 32,
    parameter int         STAGES  = 4,
    parameter int         REGW    = 5,
    parameter logic [1:0] FU_CODE = 2'd3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             is_y_valid,
    input  logic [1:0]       is_y_functionalunit,
    input  logic             is_y_signed,
    input  logic             is_y_hi,
    input  logic [WIDTH-1:0] is_y_rega,
    input  logic [WIDTH-1:0] is_y_regb,
    input  logic [REGW-1:0]  is_y_regdest,
    input  logic             is_y_flush,
    input  logic             wb_y_stall,
    output logic             y_is_ready,
    output logic [REGW-1:0]  y_wb_regdest,
    output logic             y_wb_writereg,
    output logic [WIDTH-1:0] y_wb_wbvalue,
    output logic             y_busy
);

    localparam int LAST = STAGES - 1;

    // Stage 0 holds raw operands; stage 1 onward carries the full 2*WIDTH product.
    logic [STAGES-1:0]   valid;
    logic [STAGES-1:0]   hi;
    logic [REGW-1:0]     dest [0:STAGES-1];
    logic                sgn0;
    logic [WIDTH-1:0]    a0;
    logic [WIDTH-1:0]    b0;
    logic [2*WIDTH-1:0]  prod [1:STAGES-1];

    logic                freeze;
    logic                accept;
    logic [2*WIDTH-1:0]  ext_a;
    logic [2*WIDTH-1:0]  ext_b;
    logic [2*WIDTH-1:0]  prod_s0;

    // Handshake and the stage-0 to stage-1 multiply (extended operands give an exact mod 2^2W product).
    always_comb begin
        freeze  = wb_y_stall & valid[LAST];
        accept  = is_y_valid & (is_y_functionalunit == FU_CODE) & ~freeze & ~is_y_flush;
        ext_a   = sgn0 ? {{WIDTH{a0[WIDTH-1]}}, a0} : {{WIDTH{1'b0}}, a0};
        ext_b   = sgn0 ? {{WIDTH{b0[WIDTH-1]}}, b0} : {{WIDTH{1'b0}}, b0};
        prod_s0 = ext_a * ext_b;
    end

    // Valid bits: flush beats freeze, freeze holds everything, otherwise shift one stage per cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (is_y_flush) begin
            valid <= '0;
        end else if (!freeze) begin
            valid <= {valid[STAGES-2:0], accept};
        end
    end

    // Payload: a stage loads only when valid data arrives, so the output holds its last result across bubbles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi   <= '0;
            sgn0 <= 1'b0;
            a0   <= '0;
            b0   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dest[i] <= '0;
            end
            for (int i = 1; i < STAGES; i++) begin
                prod[i] <= '0;
            end
        end else if (!freeze && !is_y_flush) begin
            if (accept) begin
                hi[0]   <= is_y_hi;
                sgn0    <= is_y_signed;
                a0      <= is_y_rega;
                b0      <= is_y_regb;
                dest[0] <= is_y_regdest;
            end
            if (valid[0]) begin
                hi[1]   <= hi[0];
                dest[1] <= dest[0];
                prod[1] <= prod_s0;
            end
            for (int i = 2; i < STAGES; i++) begin
                if (valid[i-1]) begin
                    hi[i]   <= hi[i-1];
                    dest[i] <= dest[i-1];
                    prod[i] <= prod[i-1];
                end
            end
        end
    end

    // Writeback outputs come straight from the last stage; register 0 writes are suppressed.
    always_comb begin
        y_is_ready    = ~freeze;
        y_busy        = |valid;
        y_wb_regdest  = dest[LAST];
        y_wb_writereg = valid[LAST] & (dest[LAST] != '0);
        y_wb_wbvalue  = hi[LAST] ? prod[LAST][2*WIDTH-1:WIDTH] : prod[LAST][WIDTH-1:0];
    end

endmodule
